// File: rtl/debug_frame_tx.sv
// Debug frame transmitter: snapshots a wide debug bus and streams it to a UART
// as HEADER, 16-bit length (MSB first), payload bytes (MSB first), XOR checksum.
module debug_frame_tx #(
    parameter int         BUS_WIDTH = 1736,
    parameter logic [7:0] HEADER    = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 send,
    input  logic                 mode,
    input  logic [15:0]          win_start,
    input  logic [15:0]          win_len,
    input  logic [BUS_WIDTH-1:0] send_data,
    input  logic                 tx_busy,
    output logic                 wr_uart,
    output logic [7:0]           w_data,
    output logic                 busy,
    output logic                 data_sent,
    output logic                 err
);

    localparam int NBYTES = (BUS_WIDTH + 7) / 8;
    localparam int SW     = NBYTES * 8;
    localparam int PAD    = SW - BUS_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CKSUM, S_DONE
    } state_t;

    // Byte phases: wait for tx_busy low, strobe cycle, guard cycle
    localparam logic [1:0] PH_WAIT   = 2'd0;
    localparam logic [1:0] PH_STROBE = 2'd1;
    localparam logic [1:0] PH_GUARD  = 2'd2;

    state_t          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [SW-1:0]   snap_q, snap_d;
    logic [15:0]     count_q, count_d;
    logic [15:0]     rem_q, rem_d;
    logic [7:0]      csum_q, csum_d;
    logic            wr_uart_q, wr_uart_d;
    logic [7:0]      w_data_q, w_data_d;
    logic            busy_q, busy_d;
    logic            data_sent_q, data_sent_d;
    logic            err_q, err_d;

    logic [SW-1:0]   snap_ext_s;
    logic [16:0]     win_sum_s;
    logic            win_bad_s;
    logic [7:0]      cur_byte_s;
    state_t          next_state_s;

    assign snap_ext_s = SW'(send_data) << PAD;
    assign win_sum_s  = {1'b0, win_start} + {1'b0, win_len};
    assign win_bad_s  = (win_len == 16'd0) || (32'(win_sum_s) > 32'(NBYTES));

    // Byte presented by the current sending state and the state that follows it
    always_comb begin
        cur_byte_s   = 8'h00;
        next_state_s = S_IDLE;
        case (state_q)
            S_HDR: begin
                cur_byte_s   = HEADER;
                next_state_s = S_LEN_HI;
            end
            S_LEN_HI: begin
                cur_byte_s   = count_q[15:8];
                next_state_s = S_LEN_LO;
            end
            S_LEN_LO: begin
                cur_byte_s   = count_q[7:0];
                next_state_s = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                cur_byte_s   = snap_q[SW-1 -: 8];
                next_state_s = (rem_q == 16'd1) ? S_CKSUM : S_PAYLOAD;
            end
            S_CKSUM: begin
                cur_byte_s   = csum_q;
                next_state_s = S_DONE;
            end
            default: begin
                cur_byte_s   = 8'h00;
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Next-state and output computation for the framing FSM
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        snap_d      = snap_q;
        count_d     = count_q;
        rem_d       = rem_q;
        csum_d      = csum_q;
        w_data_d    = w_data_q;
        busy_d      = busy_q;
        wr_uart_d   = 1'b0;
        data_sent_d = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (send) begin
                    if (mode && win_bad_s) begin
                        err_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_HDR;
                        phase_d = PH_WAIT;
                        csum_d  = 8'h00;
                        if (mode) begin
                            count_d = win_len;
                            rem_d   = win_len;
                            // Align the window's first byte to the top of the snapshot
                            snap_d  = snap_ext_s << {win_start, 3'b000};
                        end else begin
                            count_d = 16'(NBYTES);
                            rem_d   = 16'(NBYTES);
                            snap_d  = snap_ext_s;
                        end
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_HDR, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CKSUM: begin
                case (phase_q)
                    PH_WAIT: begin
                        if (!tx_busy) begin
                            wr_uart_d = 1'b1;
                            w_data_d  = cur_byte_s;
                            phase_d   = PH_STROBE;
                            if ((state_q != S_HDR) && (state_q != S_CKSUM)) begin
                                csum_d = csum_q ^ cur_byte_s;
                            end else begin
                                csum_d = csum_q;
                            end
                        end else begin
                            phase_d = PH_WAIT;
                        end
                    end
                    PH_STROBE: begin
                        phase_d = PH_GUARD;
                    end
                    PH_GUARD: begin
                        phase_d = PH_WAIT;
                        state_d = next_state_s;
                        if (state_q == S_PAYLOAD) begin
                            snap_d = snap_q << 4'd8;
                            rem_d  = rem_q - 16'd1;
                        end else begin
                            snap_d = snap_q;
                        end
                        if (state_q == S_CKSUM) begin
                            data_sent_d = 1'b1;
                            busy_d      = 1'b0;
                        end else begin
                            busy_d      = 1'b1;
                        end
                    end
                    default: begin
                        phase_d = PH_WAIT;
                    end
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered-output flops
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_WAIT;
            snap_q      <= '0;
            count_q     <= 16'd0;
            rem_q       <= 16'd0;
            csum_q      <= 8'h00;
            wr_uart_q   <= 1'b0;
            w_data_q    <= 8'h00;
            busy_q      <= 1'b0;
            data_sent_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            snap_q      <= snap_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            csum_q      <= csum_d;
            wr_uart_q   <= wr_uart_d;
            w_data_q    <= w_data_d;
            busy_q      <= busy_d;
            data_sent_q <= data_sent_d;
            err_q       <= err_d;
        end
    end

    assign wr_uart   = wr_uart_q;
    assign w_data    = w_data_q;
    assign busy      = busy_q;
    assign data_sent = data_sent_q;
    assign err       = err_q;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Scoreboard bench for debug_frame_tx: a 20-bit instance for directed frames and
// a default-width instance for the full 1736-bit dump.
module tb_debug_frame_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 20-bit instance
    logic        a_send = 1'b0, a_mode = 1'b0;
    logic [15:0] a_ws = 16'd0, a_wl = 16'd0;
    logic [19:0] a_data = 20'h0;
    logic        a_txb, a_wr, a_busy, a_ds, a_err;
    logic [7:0]  a_wdata;
    logic [1:0]  a_cnt;

    // default-width instance
    logic          b_send = 1'b0, b_mode = 1'b0;
    logic [15:0]   b_ws = 16'd0, b_wl = 16'd0;
    logic [1735:0] b_data = '0;
    logic          b_txb, b_wr, b_busy, b_ds, b_err;
    logic [7:0]    b_wdata;
    logic [1:0]    b_cnt;

    debug_frame_tx #(.BUS_WIDTH(20)) dut_a (
        .clock(clk), .reset(rst_n), .send(a_send), .mode(a_mode),
        .win_start(a_ws), .win_len(a_wl), .send_data(a_data), .tx_busy(a_txb),
        .wr_uart(a_wr), .w_data(a_wdata), .busy(a_busy), .data_sent(a_ds), .err(a_err)
    );

    debug_frame_tx dut_b (
        .clock(clk), .reset(rst_n), .send(b_send), .mode(b_mode),
        .win_start(b_ws), .win_len(b_wl), .send_data(b_data), .tx_busy(b_txb),
        .wr_uart(b_wr), .w_data(b_wdata), .busy(b_busy), .data_sent(b_ds), .err(b_err)
    );

    // UART models: busy for 3 cycles after each strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= 2'd0;
            b_cnt <= 2'd0;
        end else begin
            a_cnt <= a_wr ? 2'd3 : (a_cnt != 2'd0 ? a_cnt - 2'd1 : 2'd0);
            b_cnt <= b_wr ? 2'd3 : (b_cnt != 2'd0 ? b_cnt - 2'd1 : 2'd0);
        end
    end
    assign a_txb = (a_cnt != 2'd0);
    assign b_txb = (b_cnt != 2'd0);

    logic [7:0] a_q[$];
    logic [7:0] b_q[$];
    int a_stb = 0, b_stb = 0;
    int a_done_exp = 0, b_done_exp = 0;
    int a_err_exp = 0, b_err_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for instance A
    always @(negedge clk) begin : mon_a
        logic [7:0] e;
        if (a_wr) begin
            a_stb++;
            check("a_strobe_expected", {31'd0, a_q.size() != 0}, 32'd1);
            if (a_q.size() != 0) begin
                e = a_q.pop_front();
                check("a_byte", {24'd0, a_wdata}, {24'd0, e});
            end
        end
        if (a_ds) begin
            check("a_done_expected", {31'd0, a_done_exp != 0}, 32'd1);
            check("a_busy_at_done", {31'd0, a_busy}, 32'd0);
            if (a_done_exp != 0) a_done_exp--;
        end
        if (a_err) begin
            check("a_err_expected", {31'd0, a_err_exp != 0}, 32'd1);
            if (a_err_exp != 0) a_err_exp--;
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin : mon_b
        logic [7:0] e;
        if (b_wr) begin
            b_stb++;
            check("b_strobe_expected", {31'd0, b_q.size() != 0}, 32'd1);
            if (b_q.size() != 0) begin
                e = b_q.pop_front();
                check("b_byte", {24'd0, b_wdata}, {24'd0, e});
            end
        end
        if (b_ds) begin
            check("b_done_expected", {31'd0, b_done_exp != 0}, 32'd1);
            check("b_busy_at_done", {31'd0, b_busy}, 32'd0);
            if (b_done_exp != 0) b_done_exp--;
        end
        if (b_err) begin
            check("b_err_expected", {31'd0, b_err_exp != 0}, 32'd1);
            if (b_err_exp != 0) b_err_exp--;
        end
    end

    task automatic a_go(input logic m, input logic [15:0] ws, input logic [15:0] wl);
        @(negedge clk);
        a_send = 1'b1; a_mode = m; a_ws = ws; a_wl = wl;
        @(negedge clk);
        a_send = 1'b0;
    endtask

    task automatic wait_a(input string name, input int limit);
        int ok = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            #1;
            if (a_q.size() == 0 && a_done_exp == 0 && !a_busy) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 32'd1);
    endtask

    task automatic wait_b(input string name, input int limit);
        int ok = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            #1;
            if (b_q.size() == 0 && b_done_exp == 0 && !b_busy) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 32'd1);
    endtask

    task automatic wait_a_strobes(input string name, input int target, input int limit);
        int ok = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            #1;
            if (a_stb >= target) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 32'd1);
    endtask

    initial begin
        #1;
        check("rst_wr", {31'd0, a_wr}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_ds", {31'd0, a_ds}, 32'd0);
        check("rst_err", {31'd0, a_err}, 32'd0);
        check("rst_wdata", {24'd0, a_wdata}, 32'd0);
        check("rst_b_busy", {31'd0, b_busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full frame, 20-bit bus
        begin
            logic [7:0] v[7];
            v = '{8'hA5, 8'h00, 8'h03, 8'hAB, 8'hCD, 8'hE0, 8'h85};
            foreach (v[k]) a_q.push_back(v[k]);
        end
        a_done_exp = 1;
        a_data = 20'hABCDE;
        a_go(1'b0, 16'd0, 16'd0);
        check("a_busy_after_accept", {31'd0, a_busy}, 32'd1);
        wait_a("a_full_complete", 500);

        // Window of one byte in the middle
        begin
            logic [7:0] v[5];
            v = '{8'hA5, 8'h00, 8'h01, 8'hCD, 8'hCC};
            foreach (v[k]) a_q.push_back(v[k]);
        end
        a_done_exp = 1;
        a_go(1'b1, 16'd1, 16'd1);
        wait_a("a_window_complete", 500);

        // Window ending exactly at the last byte
        begin
            logic [7:0] v[5];
            v = '{8'hA5, 8'h00, 8'h01, 8'hE0, 8'hE1};
            foreach (v[k]) a_q.push_back(v[k]);
        end
        a_done_exp = 1;
        a_go(1'b1, 16'd2, 16'd1);
        wait_a("a_window_edge_complete", 500);

        // Rejections: overrun and zero length
        a_err_exp = 1;
        a_go(1'b1, 16'd2, 16'd2);
        check("a_busy_on_reject", {31'd0, a_busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("a_err_seen_overrun", a_err_exp, 32'd0);
        check("a_idle_after_overrun", {31'd0, a_busy}, 32'd0);
        a_err_exp = 1;
        a_go(1'b1, 16'd0, 16'd0);
        check("a_busy_on_reject0", {31'd0, a_busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("a_err_seen_zero", a_err_exp, 32'd0);

        // Snapshot stability and send-while-busy ignored
        begin
            logic [7:0] v[7];
            v = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'h50, 8'h75};
            foreach (v[k]) a_q.push_back(v[k]);
        end
        a_done_exp = 1;
        a_data = 20'h12345;
        a_go(1'b0, 16'd0, 16'd0);
        wait_a_strobes("a_snap_reach_2", a_stb + 1, 200);
        a_data = 20'hFFFFF;
        a_mode = 1'b1;
        a_send = 1'b1;
        @(negedge clk);
        a_send = 1'b0;
        wait_a("a_snap_complete", 500);
        repeat (40) @(negedge clk);
        check("a_no_second_frame", {31'd0, a_busy}, 32'd0);

        // Default-width full dump
        for (int i = 0; i < 217; i++) b_data[1735 - 8*i -: 8] = 8'(i * 37 + 11);
        begin
            logic [7:0] cs;
            cs = 8'h00 ^ 8'hD9;
            b_q.push_back(8'hA5);
            b_q.push_back(8'h00);
            b_q.push_back(8'hD9);
            for (int i = 0; i < 217; i++) begin
                b_q.push_back(8'(i * 37 + 11));
                cs = cs ^ 8'(i * 37 + 11);
            end
            b_q.push_back(cs);
        end
        b_done_exp = 1;
        @(negedge clk);
        b_send = 1'b1;
        @(negedge clk);
        b_send = 1'b0;
        wait_b("b_full_complete", 5000);
        check("b_strobe_count", b_stb, 32'd221);

        // Reset after the 5th strobe of a frame
        begin
            logic [7:0] v[7];
            v = '{8'hA5, 8'h00, 8'h03, 8'hAB, 8'hCD, 8'hE0, 8'h85};
            foreach (v[k]) a_q.push_back(v[k]);
        end
        a_done_exp = 1;
        a_data = 20'hABCDE;
        begin
            int base;
            base = a_stb;
            a_go(1'b0, 16'd0, 16'd0);
            wait_a_strobes("a_reach_5", base + 5, 300);
        end
        rst_n = 1'b0;
        #1;
        check("a_wr_async_rst", {31'd0, a_wr}, 32'd0);
        check("a_busy_async_rst", {31'd0, a_busy}, 32'd0);
        a_q.delete();
        a_done_exp = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("a_idle_after_rst", {31'd0, a_busy}, 32'd0);
        begin
            logic [7:0] v[6];
            v = '{8'hA5, 8'h00, 8'h02, 8'hAB, 8'hCD, 8'h64};
            foreach (v[k]) a_q.push_back(v[k]);
        end
        a_done_exp = 1;
        a_go(1'b1, 16'd0, 16'd2);
        wait_a("a_post_rst_complete", 500);

        repeat (10) @(negedge clk);
        check("a_queue_drained", a_q.size(), 32'd0);
        check("b_queue_drained", b_q.size(), 32'd0);
        check("a_err_drained", a_err_exp, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
